jtvigil_prio_mix: RTL and testbench
===================================

# jtvigil_prio_mix

Parametrised colour mixer for JTVIGIL-class boards; sits between the tile/sprite generators and the video output. Accepts NL layer pixels, resolves priority with a CPU-programmable rank order and per-layer override, then fetches R, G and B from a shared CPU-writable palette RAM over several clock cycles. It drives blanked RGB one pixel after input.

## Interface
Parameters:
- NL, 3: number of layers, 2..4.
- PW, 8: pixel/palette-index width per layer.
- CTW, 4: low pixel bits that define transparency (all zero = transparent).
- CW, 5: colour bits per channel.
- AW, PW+4: palette address width, {layer[1:0], chan[1:0], index[PW-1:0]}.

Ports:
- clk  in  1  single system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous reset, active high.
- pxl_cen  in  1  pixel clock enable; at least 5 clk cycles between pulses.
- LHBL, LVBL  in  1 each  active-low blanking, aligned with layer pixels.
- main_addr  in  AW  CPU address.
- main_dout  in  8  CPU write data.
- main_din  out  8  palette read data, 1 clk latency after address.
- main_rnw  in  1  1 = read.
- pal_cs  in  1  palette select.
- prio_cs  in  1  priority-register select; main_addr[0] picks the register.
- lyr_pxl  in  NL*PW  layer pixels; layer n at [n*PW +: PW].
- gfx_en  in  4  debug layer enables; bit n low forces layer n transparent.
- red, green, blue  out  CW each  registered colour.

## Operation
- Palette RAM: 2^AW bytes, dual port on clk. CPU writes when pal_cs & ~main_rnw. Colour is byte[CW-1:0]; chan 0=R, 1=G, 2=B, 3 unused. A simultaneous CPU write and video read at the same address returns old data to the video port.
- Priority registers, written when prio_cs & ~main_rnw:
  - addr[0]=0: order[7:0], with rank r layer at order[2r+1:2r] and rank 0 highest. Reset 8'hE4.
  - addr[0]=1: ovr[3:0]. Reset 0.
  - Reads of the priority registers return 0.
- Opaque(n): n<NL, gfx_en[n]=1 and lyr_pxl_n[CTW-1:0]!=0.
- Override(n): opaque(n), ovr[n]=1 and lyr_pxl_n[PW-1:PW-2]==3.
- Winner selection:
  - If any layer has override, the lowest-numbered such layer wins.
  - Otherwise scan ranks 0..3; the first rank whose layer is opaque wins.
  - Rank entries ≥NL and duplicate entries are skipped naturally by the scan.
  - If no layer is opaque, use the backdrop: layer = order[2(NL-1)+1:2(NL-1)] clipped to NL-1, index 0.
- Fetch FSM:
  - States: IDLE, FR, FG, FB. Reset state is IDLE.
  - pxl_cen in any state: latch winner layer/index and blank = ~LHBL|~LVBL, then go to FR. A pxl_cen arriving mid-fetch aborts the fetch; pre-registers keep their last values.
  - FR: address chan 0, then go to FG.
  - FG: capture pre_r, address chan 1, then go to FB.
  - FB: capture pre_g, address chan 2, then go to IDLE.
  - IDLE: capture pre_b on the first cycle only.
- Output: on pxl_cen, {red,green,blue} <= blank_latched ? 0 : {pre_r,pre_g,pre_b}. The blank flag used is the one latched with the pixel being output.

## Timing
- Reset:
  - red/green/blue = 0, main_din = 0.
  - order = 8'hE4, ovr = 0.
  - FSM in IDLE, pre_* = 0, blank_latched = 1.
- Edge c0 is the pxl_cen edge that latches pixel P.
  - R address presented during c0..c1, data captured at c2.
  - G captured at c3, B captured at c4.
- RGB for P appears at the next pxl_cen edge (≥c5). Latency is exactly one pixel period.
- CPU read: main_din is valid 1 clk after main_addr with pal_cs & main_rnw. main_din holds its value otherwise.
- Priority register writes affect the next pxl_cen latch.

## Test plan
- Reset, then pxl_cen every 8 clk with all layers 0 and blanking inactive: output 0 (backdrop index 0 of layer 2, palette cleared).
- Write pal[{2'd1,2'd0,8'h15}]=5'h1F, G slot=5'h0A, B slot=5'h03. Drive layer1 pixel 8'h15, layer0 pixel 0: next pixel gives red=1F, green=0A, blue=03.
- Layer0=8'h12 and layer1=8'h15 with order=E4: layer0 colour wins. Write order=8'hE1: layer1 wins on the following pixel.
- Set ovr=4'b0100 and layer2 pixel=8'hC1 with layers 0 and 1 opaque: layer2 wins. Change layer2 to 8'h81: rank order applies again.
- Clear gfx_en[0] with layer0 opaque: layer0 is ignored. Assert LHBL=0 on one pixel: that pixel's output is 0 and the neighbouring pixels are unaffected.
- Assert rst mid-fetch (state FG): all outputs 0 and order=E4 on the next cycle. The first pixel after release matches the golden value.

Source files
------------

// File: rtl/jtvigil_prio_mix.sv
// Layer priority resolver and palette colour fetch for JTVIGIL-class video.
// One pixel in per pxl_cen, R/G/B fetched serially from a shared palette RAM.
module jtvigil_prio_mix #(
  parameter int NL  = 3,
  parameter int PW  = 8,
  parameter int CTW = 4,
  parameter int CW  = 5,
  parameter int AW  = PW + 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic            LHBL,
  input  logic            LVBL,
  input  logic [AW-1:0]   main_addr,
  input  logic [7:0]      main_dout,
  output logic [7:0]      main_din,
  input  logic            main_rnw,
  input  logic            pal_cs,
  input  logic            prio_cs,
  input  logic [NL*PW-1:0] lyr_pxl,
  input  logic [3:0]      gfx_en,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue
);
  typedef enum logic [1:0] {IDLE, FR, FG, FB} st_t;

  st_t           st;
  logic [7:0]    order;
  logic [3:0]    ovr;
  logic [7:0]    pal [0:2**AW-1];
  logic [CW-1:0] vid_q;
  logic [AW-1:0] vid_addr;
  logic [1:0]    vid_chan;
  logic [1:0]    lat_lyr, win_lyr, bd_lyr;
  logic [PW-1:0] lat_idx, win_idx;
  logic [PW-1:0] pix [4];
  logic [3:0]    opq, ovh;
  logic          found;
  logic          blank_l, cap_b;
  logic [CW-1:0] pre_r, pre_g, pre_b;

  // Winner resolution: overrides first (lowest layer), then rank scan, else backdrop.
  always_comb begin
    for (int n = 0; n < 4; n++) pix[n] = '0;
    for (int n = 0; n < NL; n++) pix[n] = lyr_pxl[n*PW +: PW];
    opq = '0;
    ovh = '0;
    for (int n = 0; n < 4; n++) begin
      opq[n] = (n < NL) && gfx_en[n] && (pix[n][CTW-1:0] != '0);
      ovh[n] = opq[n] && ovr[n] && (pix[n][PW-1 -: 2] == 2'b11);
    end
    bd_lyr  = (order[2*(NL-1) +: 2] > 2'(NL-1)) ? 2'(NL-1) : order[2*(NL-1) +: 2];
    found   = 1'b0;
    win_lyr = bd_lyr;
    win_idx = '0;
    for (int n = 0; n < 4; n++) begin
      if (!found && ovh[n]) begin
        found   = 1'b1;
        win_lyr = 2'(n);
        win_idx = pix[n];
      end
    end
    // Ranks pointing at absent layers never have opq set, so they fall through.
    for (int r = 0; r < 4; r++) begin
      if (!found && opq[order[2*r +: 2]]) begin
        found   = 1'b1;
        win_lyr = order[2*r +: 2];
        win_idx = pix[order[2*r +: 2]];
      end
    end
  end

  always_comb begin
    case (st)
      FG:      vid_chan = 2'd1;
      FB:      vid_chan = 2'd2;
      default: vid_chan = 2'd0;
    endcase
    vid_addr = {lat_lyr, vid_chan, lat_idx};
  end

  // Palette RAM: write-first is not wanted, so the registered read sees old data.
  always_ff @(posedge clk) begin
    if (pal_cs && !main_rnw) pal[main_addr] <= main_dout;
    vid_q <= pal[vid_addr][CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_din <= '0;
      order    <= 8'hE4;
      ovr      <= '0;
    end else begin
      if (pal_cs && main_rnw)       main_din <= pal[main_addr];
      else if (prio_cs && main_rnw) main_din <= '0;
      if (prio_cs && !main_rnw) begin
        if (main_addr[0]) ovr   <= main_dout[3:0];
        else              order <= main_dout;
      end
    end
  end

  // Fetch sequencer; a new pixel always restarts the fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      lat_lyr <= '0;
      lat_idx <= '0;
      blank_l <= 1'b1;
      cap_b   <= 1'b0;
      pre_r   <= '0;
      pre_g   <= '0;
      pre_b   <= '0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else if (pxl_cen) begin
      {red, green, blue} <= blank_l ? '0 : {pre_r, pre_g, pre_b};
      lat_lyr <= win_lyr;
      lat_idx <= win_idx;
      blank_l <= ~LHBL | ~LVBL;
      cap_b   <= 1'b0;
      st      <= FR;
    end else begin
      case (st)
        FR: st <= FG;
        FG: begin
          pre_r <= vid_q;
          st    <= FB;
        end
        FB: begin
          pre_g <= vid_q;
          cap_b <= 1'b1;
          st    <= IDLE;
        end
        default: begin
          if (cap_b) pre_b <= vid_q;
          cap_b <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtvigil_prio_mix.sv
// Bench for jtvigil_prio_mix: directed vector table, reset-mid-fetch, random vs model.
module tb_jtvigil_prio_mix;
  logic        clk = 0, rst = 1, pxl_cen = 0, LHBL = 1, LVBL = 1;
  logic        main_rnw = 1, pal_cs = 0, prio_cs = 0;
  logic [11:0] main_addr = '0;
  logic [7:0]  main_dout = '0, main_din;
  logic [23:0] lyr_pxl = '0;
  logic [3:0]  gfx_en = 4'hF;
  logic [4:0]  red, green, blue;

  jtvigil_prio_mix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .main_addr(main_addr), .main_dout(main_dout), .main_din(main_din),
    .main_rnw(main_rnw), .pal_cs(pal_cs), .prio_cs(prio_cs),
    .lyr_pxl(lyr_pxl), .gfx_en(gfx_en), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [7:0]  tb_pal [4096];
  logic [7:0]  m_order = 8'hE4;
  logic [3:0]  m_ovr = '0;
  logic [14:0] exp_prev = '0;

  typedef struct {
    logic [7:0]  p0, p1, p2;
    logic [3:0]  en;
    bit          hb, vb;
    logic [7:0]  ord;
    logic [3:0]  ov;
    logic [14:0] expv;
  } vec_t;
  vec_t vt [18];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [14:0] rgb(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    return {r, g, b};
  endfunction

  // Reference: colour of a pixel from the rules, using the shadow palette/registers.
  function automatic logic [14:0] model(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [3:0] en, input bit blank);
    logic [7:0] px [3];
    int w, l, base;
    logic [7:0] idx;
    px[0] = p0; px[1] = p1; px[2] = p2;
    if (blank) return '0;
    w = -1;
    for (int n = 0; n < 3; n++)
      if (w < 0 && en[n] && px[n][3:0] != 0 && m_ovr[n] && px[n][7:6] == 2'b11) w = n;
    for (int r = 0; r < 4; r++) begin
      l = int'((m_order >> (2*r)) & 8'd3);
      if (w < 0 && l < 3 && en[l] && px[l][3:0] != 0) w = l;
    end
    if (w < 0) begin
      l = int'((m_order >> 4) & 8'd3);
      if (l > 2) l = 2;
      idx = 8'h00;
    end else begin
      l = w;
      idx = px[w];
    end
    base = l*1024 + int'(idx);
    return {tb_pal[base][4:0], tb_pal[base+256][4:0], tb_pal[base+512][4:0]};
  endfunction

  task automatic cpu_wr(input bit is_pal, input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    main_addr = a; main_dout = d; main_rnw = 0; pal_cs = is_pal; prio_cs = !is_pal;
    @(posedge clk); #1;
    pal_cs = 0; prio_cs = 0; main_rnw = 1;
    if (is_pal) tb_pal[a] = d;
    else if (a[0]) m_ovr = d[3:0];
    else m_order = d;
  endtask

  task automatic pal_wr(input int l, input int ch, input int idx, input logic [7:0] d);
    cpu_wr(1'b1, 12'(l*1024 + ch*256 + idx), d);
  endtask

  task automatic cpu_rd(input logic [11:0] a, input bit is_pal, input string nm);
    logic [7:0] e;
    e = is_pal ? tb_pal[a] : 8'h00;
    @(negedge clk);
    main_addr = a; main_rnw = 1; pal_cs = is_pal; prio_cs = !is_pal;
    @(posedge clk); #1;
    pal_cs = 0; prio_cs = 0;
    check(nm, {8'h00, main_din}, {8'h00, e});
    @(posedge clk); #1;
    check({nm, "_hold"}, {8'h00, main_din}, {8'h00, e});
  endtask

  // One pixel: pulse pxl_cen, check the previous pixel's colour, remember this one's.
  task automatic send_px(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [3:0] en, input bit hb, input bit vb, input int gap,
                         input logic [14:0] expv, input string nm);
    @(negedge clk);
    lyr_pxl = {p2, p1, p0}; gfx_en = en; LHBL = hb; LVBL = vb; pxl_cen = 1;
    @(posedge clk); #1;
    pxl_cen = 0;
    check(nm, {1'b0, red, green, blue}, {1'b0, exp_prev});
    exp_prev = expv;
    repeat (gap-1) @(posedge clk);
  endtask

  function automatic logic [7:0] rpx();
    logic [7:0] v;
    v = 8'($urandom);
    case ($urandom_range(0, 3))
      0: v[3:0] = 4'h0;
      1: v[7:6] = 2'b11;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    vt[0]  = '{8'h00, 8'h00, 8'h00, 4'hF, 1, 1, 8'hE4, 4'h0, 15'h0};
    vt[1]  = '{8'h00, 8'h15, 8'h00, 4'hF, 1, 1, 8'hE4, 4'h0, rgb(5'h1F, 5'h0A, 5'h03)};
    vt[2]  = '{8'h12, 8'h15, 8'h00, 4'hF, 1, 1, 8'hE4, 4'h0, rgb(5'h04, 5'h05, 5'h06)};
    vt[3]  = '{8'h12, 8'h15, 8'h00, 4'hF, 1, 1, 8'hE1, 4'h0, rgb(5'h1F, 5'h0A, 5'h03)};
    vt[4]  = '{8'h12, 8'h15, 8'hC1, 4'hF, 1, 1, 8'hE4, 4'h4, rgb(5'h11, 5'h12, 5'h13)};
    vt[5]  = '{8'h12, 8'h15, 8'h81, 4'hF, 1, 1, 8'hE4, 4'h4, rgb(5'h04, 5'h05, 5'h06)};
    vt[6]  = '{8'h12, 8'h15, 8'h00, 4'hE, 1, 1, 8'hE4, 4'h0, rgb(5'h1F, 5'h0A, 5'h03)};
    vt[7]  = '{8'h12, 8'h15, 8'h00, 4'hF, 0, 1, 8'hE4, 4'h0, 15'h0};
    vt[8]  = '{8'h12, 8'h15, 8'h00, 4'hF, 1, 1, 8'hE4, 4'h0, rgb(5'h04, 5'h05, 5'h06)};
    vt[9]  = '{8'h10, 8'h00, 8'h00, 4'hF, 1, 1, 8'hE4, 4'h0, 15'h0};
    vt[10] = '{8'h00, 8'h00, 8'hC1, 4'hF, 1, 1, 8'hE4, 4'h0, rgb(5'h11, 5'h12, 5'h13)};
    vt[11] = '{8'h12, 8'h15, 8'hC1, 4'hF, 1, 1, 8'hE4, 4'hE, rgb(5'h11, 5'h12, 5'h13)};
    vt[12] = '{8'h00, 8'h00, 8'h00, 4'hF, 1, 1, 8'h1B, 4'h0, rgb(5'h07, 5'h08, 5'h09)};
    vt[13] = '{8'h12, 8'h00, 8'h00, 4'hF, 1, 1, 8'hD7, 4'h0, rgb(5'h07, 5'h08, 5'h09)};
    vt[14] = '{8'h12, 8'h15, 8'hC1, 4'hF, 1, 1, 8'h3F, 4'h0, rgb(5'h04, 5'h05, 5'h06)};
    vt[15] = '{8'h12, 8'h15, 8'hC1, 4'hF, 1, 1, 8'hFF, 4'h4, rgb(5'h11, 5'h12, 5'h13)};
    vt[16] = '{8'h12, 8'h15, 8'h00, 4'hF, 1, 0, 8'hE4, 4'h0, 15'h0};
    vt[17] = '{8'h12, 8'h15, 8'h00, 4'hF, 1, 1, 8'hE4, 4'h0, rgb(5'h04, 5'h05, 5'h06)};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {1'b0, red, green, blue}, 16'h0);
    check("reset_din", {8'h00, main_din}, 16'h0);
    @(negedge clk);
    rst = 0;

    for (int a = 0; a < 4096; a++) cpu_wr(1'b1, 12'(a), 8'h00);
    pal_wr(0, 0, 8'h12, 8'h04); pal_wr(0, 1, 8'h12, 8'h05); pal_wr(0, 2, 8'h12, 8'h06);
    pal_wr(1, 0, 8'h15, 8'hFF); pal_wr(1, 1, 8'h15, 8'h0A); pal_wr(1, 2, 8'h15, 8'hE3);
    pal_wr(2, 0, 8'hC1, 8'h11); pal_wr(2, 1, 8'hC1, 8'h12); pal_wr(2, 2, 8'hC1, 8'h13);
    pal_wr(1, 0, 8'h00, 8'h07); pal_wr(1, 1, 8'h00, 8'h08); pal_wr(1, 2, 8'h00, 8'h09);

    for (int i = 0; i < 18; i++) begin
      if (vt[i].ord != m_order) cpu_wr(1'b0, 12'h000, vt[i].ord);
      if (vt[i].ov != m_ovr) cpu_wr(1'b0, 12'h001, {4'h0, vt[i].ov});
      send_px(vt[i].p0, vt[i].p1, vt[i].p2, vt[i].en, vt[i].hb, vt[i].vb,
              (i % 2) ? 5 : 8, vt[i].expv, $sformatf("vec%0d", i > 0 ? i-1 : 99));
    end
    send_px(8'h00, 8'h15, 8'h00, 4'hF, 1, 1, 8, rgb(5'h1F, 5'h0A, 5'h03), "vec17");

    // Reset during the G fetch, with non-default order and non-zero CPU read data.
    cpu_wr(1'b0, 12'h000, 8'hE1);
    cpu_rd(12'h001, 1'b0, "prio_rd");
    cpu_rd(12'(1*1024 + 8'h15), 1'b1, "pal_rd");
    @(negedge clk);
    lyr_pxl = {8'h00, 8'h15, 8'h12}; gfx_en = 4'hF; LHBL = 1; LVBL = 1; pxl_cen = 1;
    @(posedge clk); #1;
    pxl_cen = 0;
    check("pre_rst_out", {1'b0, red, green, blue}, {1'b0, exp_prev});
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_rgb", {1'b0, red, green, blue}, 16'h0);
    check("rst_mid_din", {8'h00, main_din}, 16'h0);
    @(negedge clk);
    rst = 0;
    m_order = 8'hE4; m_ovr = 4'h0; exp_prev = '0;
    send_px(8'h12, 8'h15, 8'h00, 4'hF, 1, 1, 8, rgb(5'h04, 5'h05, 5'h06), "post_rst_first");
    send_px(8'h00, 8'h00, 8'h00, 4'hF, 1, 1, 8, 15'h0, "post_rst_golden");

    for (int a = 0; a < 4096; a++) cpu_wr(1'b1, 12'(a), 8'($urandom));
    for (int i = 0; i < 300; i++) begin
      logic [7:0] p0, p1, p2;
      logic [3:0] en;
      bit hb, vb;
      if ($urandom_range(0, 5) == 0) cpu_wr(1'b0, 12'h000, 8'($urandom));
      if ($urandom_range(0, 5) == 0) cpu_wr(1'b0, 12'h001, 8'($urandom));
      if ($urandom_range(0, 15) == 0) cpu_rd(12'($urandom), 1'b1, "rand_rd");
      p0 = rpx(); p1 = rpx(); p2 = rpx();
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      hb = $urandom_range(0, 9) != 0;
      vb = $urandom_range(0, 9) != 0;
      send_px(p0, p1, p2, en, hb, vb, $urandom_range(5, 9), model(p0, p1, p2, en, !(hb && vb)),
              $sformatf("rand%0d", i > 0 ? i-1 : 0));
    end
    send_px(8'h00, 8'h00, 8'h00, 4'hF, 1, 1, 8, 15'h0, "rand_last");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
